// File: rtl/gate_window_gen.sv
// Gate-window generator: drives the pulse-counter enable for L cycles per window,
// with optional G-cycle gaps between windows, start/stop control and boundary strobes.
module gate_window_gen #(
  parameter int CNT_W            = 32,
  parameter int DEFAULT_GATE_LEN = 100_000_000,
  parameter int WCNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [CNT_W-1:0]  cfg_gate_len,
  input  logic [CNT_W-1:0]  cfg_gap_len,
  output logic              enable,
  output logic              gate_start,
  output logic              gate_end,
  output logic              busy,
  output logic [WCNT_W-1:0] window_cnt
);

  typedef enum logic [1:0] {IDLE, GATE, GAP} state_t;

  localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEFAULT_GATE_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               enable_q, enable_d;
  logic               gate_start_q, gate_start_d;
  logic               gate_end_q, gate_end_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   gate_len, gap_len;

  // Zero config selects the default gate length; a zero gap is clamped to one cycle.
  assign gate_len = (cfg_gate_len == '0) ? DEF_LEN : cfg_gate_len;
  assign gap_len  = (cfg_gap_len == '0) ? ONE : cfg_gap_len;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    gate_start_d = 1'b0;
    gate_end_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d      = GATE;
          cnt_d        = gate_len - ONE;
          gate_start_d = 1'b1;
        end
      end
      GATE: begin
        // Stop discards the window even when it would have completed this edge.
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          wcnt_d     = wcnt_q + WCNT_W'(1);
          gate_end_d = 1'b1;
          if (mode) begin
            state_d = GAP;
            cnt_d   = gap_len - ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d      = GATE;
          cnt_d        = gate_len - ONE;
          gate_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    enable_d = (state_d == GATE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      enable_q     <= 1'b0;
      gate_start_q <= 1'b0;
      gate_end_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      enable_q     <= enable_d;
      gate_start_q <= gate_start_d;
      gate_end_q   <= gate_end_d;
      busy_q       <= busy_d;
    end
  end

  assign enable     = enable_q;
  assign gate_start = gate_start_q;
  assign gate_end   = gate_end_q;
  assign busy       = busy_q;
  assign window_cnt = wcnt_q;

endmodule

// File: tb/tb_gate_window_gen.sv
// Bench for gate_window_gen: vector table, directed corner sequences and random
// stimulus, all checked against a phase/remaining-cycles reference model.
module tb_gate_window_gen;
  localparam int DEF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [31:0] cfg_gate_len = '0, cfg_gap_len = '0;
  logic        enable, gate_start, gate_end, busy;
  logic [15:0] window_cnt;
  logic        enable_w, gate_start_w, gate_end_w, busy_w;
  logic [1:0]  window_cnt_w;

  gate_window_gen #(.CNT_W(32), .DEFAULT_GATE_LEN(DEF), .WCNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .cfg_gate_len(cfg_gate_len), .cfg_gap_len(cfg_gap_len),
    .enable(enable), .gate_start(gate_start), .gate_end(gate_end),
    .busy(busy), .window_cnt(window_cnt));

  gate_window_gen #(.CNT_W(32), .DEFAULT_GATE_LEN(DEF), .WCNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .cfg_gate_len(cfg_gate_len), .cfg_gap_len(cfg_gap_len),
    .enable(enable_w), .gate_start(gate_start_w), .gate_end(gate_end_w),
    .busy(busy_w), .window_cnt(window_cnt_w));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0=idle 1=gate 2=gap, m_left = cycles still to spend in phase.
  int   m_phase = 0;
  int   m_left  = 0;
  int   m_wins  = 0;
  logic exp_gs  = 1'b0;
  logic exp_ge  = 1'b0;

  int cyc = 0;
  int ge_n = 0;
  int en_run = 0;
  int gs_q[$];
  int run_q[$];
  int wq[$];

  typedef struct {
    logic s, p, md;
    int   gl;
    logic en, gs, ge, bz;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic p, input logic md, input int gl, input int gp);
    int len_l, len_g;
    len_l  = (gl == 0) ? DEF : gl;
    len_g  = (gp == 0) ? 1 : gp;
    exp_gs = 1'b0;
    exp_ge = 1'b0;
    if (m_phase == 0) begin
      if (s && !p) begin
        m_phase = 1; m_left = len_l; exp_gs = 1'b1;
      end
    end else if (p) begin
      m_phase = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase == 1) begin
          m_wins++;
          exp_ge = 1'b1;
          if (md) begin m_phase = 2; m_left = len_g; end
          else m_phase = 0;
        end else begin
          m_phase = 1; m_left = len_l; exp_gs = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_track();
    ge_n = 0; en_run = 0;
    gs_q.delete(); run_q.delete(); wq.delete();
  endtask

  task automatic cycle(input logic s, input logic p, input logic md, input int gl, input int gp);
    start = s; stop = p; mode = md;
    cfg_gate_len = 32'(gl); cfg_gap_len = 32'(gp);
    @(posedge clk);
    model_step(s, p, md, gl, gp);
    #1;
    cyc++;
    check("enable", {31'b0, enable}, {31'b0, m_phase == 1});
    check("gate_start", {31'b0, gate_start}, {31'b0, exp_gs});
    check("gate_end", {31'b0, gate_end}, {31'b0, exp_ge});
    check("busy", {31'b0, busy}, {31'b0, m_phase != 0});
    check("window_cnt", {16'b0, window_cnt}, {16'b0, m_wins[15:0]});
    check("window_cnt_w2", {30'b0, window_cnt_w}, {30'b0, m_wins[1:0]});
    check("strobe_overlap", {31'b0, gate_start & gate_end}, 32'd0);
    if (gate_start) gs_q.push_back(cyc);
    if (gate_end) begin ge_n++; wq.push_back(int'(window_cnt_w)); end
    if (enable) en_run++;
    else if (en_run != 0) begin run_q.push_back(en_run); en_run = 0; end
  endtask

  // Asserts reset between edges and checks outputs clear before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_enable", {31'b0, enable}, 32'd0);
    check("rst_gate_start", {31'b0, gate_start}, 32'd0);
    check("rst_gate_end", {31'b0, gate_end}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_window_cnt", {16'b0, window_cnt}, 32'd0);
    m_phase = 0; m_left = 0; m_wins = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    en_run = 0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};

    #1;
    async_reset();

    // Vector table: start+stop in idle, 2-cycle single shots, held-start restart, abort.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].s, tbl[i].p, tbl[i].md, tbl[i].gl, 1);
      check($sformatf("tbl%0d_enable", i), {31'b0, enable}, {31'b0, tbl[i].en});
      check($sformatf("tbl%0d_gate_start", i), {31'b0, gate_start}, {31'b0, tbl[i].gs});
      check($sformatf("tbl%0d_gate_end", i), {31'b0, gate_end}, {31'b0, tbl[i].ge});
      check($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].bz});
    end
    check("tbl_windows", {16'b0, window_cnt}, 32'd2);

    // Reset mid-gate, then L=5 starts one edge after start.
    cycle(1'b1, 1'b0, 1'b0, 8, 1);
    cycle(1'b0, 1'b0, 1'b0, 8, 1);
    async_reset();
    clear_track();
    cycle(1'b1, 1'b0, 1'b0, 5, 1);
    check("l5_start_enable", {31'b0, enable}, 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 5, 1);
    check("l5_run", run_q.size() > 0 ? run_q[0] : -1, 32'd5);

    // Single shot L=10.
    clear_track();
    cycle(1'b1, 1'b0, 1'b0, 10, 1);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b0, 10, 1);
    check("ss_run", run_q.size() > 0 ? run_q[0] : -1, 32'd10);
    check("ss_ge_n", ge_n, 32'd1);

    // Continuous L=4 G=3, five windows, period 7.
    async_reset();
    clear_track();
    cycle(1'b1, 1'b0, 1'b1, 4, 3);
    for (int i = 0; i < 60 && ge_n < 5; i++) cycle(1'b0, 1'b0, 1'b1, 4, 3);
    check("cont_ge_n", ge_n, 32'd5);
    check("cont_window_cnt", {16'b0, window_cnt}, 32'd5);
    check("cont_period_a", gs_q.size() >= 2 ? gs_q[1] - gs_q[0] : -1, 32'd7);
    check("cont_period_b", gs_q.size() >= 5 ? gs_q[4] - gs_q[3] : -1, 32'd7);
    check("cont_run", run_q.size() >= 5 ? run_q[4] : -1, 32'd4);
    cycle(1'b0, 1'b1, 1'b1, 4, 3);

    // L changed mid-gate applies from the next window only.
    clear_track();
    cycle(1'b1, 1'b0, 1'b1, 4, 3);
    for (int i = 0; i < 40 && ge_n < 2; i++) cycle(1'b0, 1'b0, 1'b1, 6, 3);
    check("lchg_run0", run_q.size() >= 1 ? run_q[0] : -1, 32'd4);
    check("lchg_run1", run_q.size() >= 2 ? run_q[1] : -1, 32'd6);
    cycle(1'b0, 1'b1, 1'b1, 6, 3);

    // Zero config: default 20-cycle gates, 1-cycle gap.
    clear_track();
    cycle(1'b1, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 200 && ge_n < 3; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);
    check("zero_run0", run_q.size() >= 1 ? run_q[0] : -1, 32'd20);
    check("zero_run2", run_q.size() >= 3 ? run_q[2] : -1, 32'd20);
    check("zero_period", gs_q.size() >= 3 ? gs_q[2] - gs_q[1] : -1, 32'd21);
    cycle(1'b0, 1'b1, 1'b1, 0, 0);

    // Abort in the 3rd gate cycle of L=8; then stop on the final gate cycle.
    clear_track();
    cycle(1'b1, 1'b0, 1'b0, 8, 1);
    cycle(1'b0, 1'b0, 1'b0, 8, 1);
    cycle(1'b0, 1'b0, 1'b0, 8, 1);
    cycle(1'b0, 1'b1, 1'b0, 8, 1);
    check("abort_enable", {31'b0, enable}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8, 1);
    check("abort_ge_n", ge_n, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 2, 1);
    cycle(1'b0, 1'b0, 1'b0, 2, 1);
    cycle(1'b0, 1'b1, 1'b0, 2, 1);
    cycle(1'b0, 1'b0, 1'b0, 2, 1);
    check("abort_end_ge_n", ge_n, 32'd0);

    // Window counter wrap on the 2-bit instance, L=1 G=1.
    async_reset();
    clear_track();
    cycle(1'b1, 1'b0, 1'b1, 1, 1);
    for (int i = 0; i < 30 && ge_n < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1, 1);
    check("wrap_ge_n", ge_n, 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("wrap_seq%0d", i), wq.size() > i ? wq[i] : -1, (i + 1) % 4);
    cycle(1'b0, 1'b1, 1'b1, 1, 1);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gate_window_gen.md
# gate_window_gen

Parametrised gate-window generator for the frequency meter: the programmable successor to the fixed 1 s enable toggler. It drives the `enable` gate that qualifies the input-pulse counters. It supports runtime gate length, an inter-window gap for counter readout, single-shot and continuous modes, start/stop control, and window-boundary strobes. It sits between the control/config registers and the pulse counters; `gate_end` is the counter-latch trigger.

## Interface
- `CNT_W`, default 32: width of the gate and gap length counters.
- `DEFAULT_GATE_LEN`, default 100_000_000: gate length in cycles used when `cfg_gate_len` is 0 (1 s at 100 MHz).
- `WCNT_W`, default 16: width of the completed-window counter.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level, sampled only in IDLE; begins a window.
- `stop`  in  1  level; aborts any window in progress.
- `mode`  in  1  0 = single-shot, 1 = continuous.
- `cfg_gate_len`  in  CNT_W  gate length in cycles; 0 selects `DEFAULT_GATE_LEN`.
- `cfg_gap_len`  in  CNT_W  low time between continuous windows, in cycles; 0 is clamped to 1.
- `enable`  out  1  gate to the pulse counters, registered.
- `gate_start`  out  1  one-cycle strobe coincident with the first high cycle of `enable`.
- `gate_end`  out  1  one-cycle strobe on the first low cycle after a completed gate.
- `busy`  out  1  high whenever the state is not IDLE.
- `window_cnt`  out  WCNT_W  count of completed windows; wraps modulo 2^WCNT_W.

## Operation
- States are IDLE, GATE and GAP. `enable` is 1 only in GATE.
- **Reset:** state goes to IDLE, and `enable`, `gate_start`, `gate_end`, `busy` and `window_cnt` go to 0 immediately (asynchronous), including mid-window. Counters are cleared.
- **IDLE → GATE:** when `start`=1 and `stop`=0. On entry:
  - the gate length L is latched (`cfg_gate_len`, or `DEFAULT_GATE_LEN` if 0);
  - the down-counter is loaded with L−1;
  - `gate_start` is pulsed.
- **GATE:**
  - The counter decrements each cycle. When the counter is 0, the gate ends at the next edge.
  - At the end of the gate: `window_cnt` increments, `gate_end` is asserted for the next cycle, and `mode` is sampled.
  - If `mode`=0, go to IDLE.
  - If `mode`=1, go to GAP. The gap length G is latched (`cfg_gap_len`, min 1) and the counter is loaded with G−1.
- **GAP:** the counter decrements. At 0, go to GATE: L is re-latched, the counter is loaded with L−1, and `gate_start` is pulsed.
- **`stop`=1 in GATE or GAP:** go to IDLE at the next edge. `enable` drops, no `gate_end` is issued, and `window_cnt` does not change.
- **`stop` priority:** `stop` wins over `start`, and over a gate ending in the same cycle. In that case the window is discarded and not counted.
- **Ignored inputs:** `start` is ignored outside IDLE. Config changes take effect only at the next latch point.
- **Widths:** the counters are CNT_W wide and unsigned. L = 1 yields a single-cycle gate.

## Timing
- **Start latency:** `start` high at edge N in IDLE gives `enable`=1 and `gate_start`=1 from edge N+1.
- **Gate width:** `enable` is high for exactly L cycles, and `busy` rises together with `enable`.
- **Gate end:** `gate_end` is high for the one cycle immediately after the last `enable`-high cycle.
  - Single-shot: `busy` is already 0 in that cycle.
  - Continuous: `busy` stays 1.
- **Continuous period:** period = L+G cycles. `enable` is low for exactly G cycles between gates, and `gate_end` coincides with the first gap cycle.
- **Restart after single-shot:** `start` held high re-triggers on the edge after IDLE is reached, so `enable` is low for exactly 1 cycle between back-to-back single-shot windows.
- **Strobes:** `gate_start` and `gate_end` are never high in the same cycle.

## Test plan
- **Reset behaviour:** assert `rst` mid-GATE → all outputs are 0 within the same cycle (asynchronous). Release, then pulse `start` with L=5 → gate begins one edge after `start`.
- **Single-shot:** `mode`=0, L=10, one-cycle `start` → `enable` high exactly 10 cycles, `gate_start` on the 1st, `gate_end` on the 11th cycle, `busy` low on the 11th, `window_cnt`=1.
- **Continuous:** `mode`=1, L=4, G=3, run 5 windows → period 7, 5× `gate_end`, `window_cnt`=5. Changing L to 6 during a gate affects only the next window.
- **Zero config:** `cfg_gate_len`=0 with `DEFAULT_GATE_LEN` overridden to 20, `cfg_gap_len`=0 → gates of 20 cycles separated by a 1-cycle low gap.
- **Abort:** assert `stop` in the 3rd GATE cycle of L=8 → `enable` low next cycle, no `gate_end`, `window_cnt` unchanged. `start`+`stop` together in IDLE → stays IDLE.
- **Wrap:** `WCNT_W`=2, L=1, G=1, continuous → `window_cnt` sequence 1,2,3,0,1; check `gate_end` count against the expected number of completed windows.
